// File: rtl/tone_synth.sv
// tone_synth: multi-voice square-wave tone generator.
// Voices are mixed, volume-scaled and rendered as PWM density on one pin.
module tone_synth #(
  parameter int CLK_HZ = 100_000_000,
  parameter int VOICES = 2,
  parameter int VOL_W  = 3,
  parameter int PWM_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6*VOICES-1:0] note,
  input  logic [2*VOICES-1:0] oct,
  input  logic [VOL_W-1:0]    vol,
  output logic [VOICES-1:0]   active,
  output logic                speaker
);

  // Longest half period is C3 shifted down one octave.
  localparam longint HMAX =
    2 * (longint'(382226) * CLK_HZ / 100000000);
  localparam int HW = $clog2(HMAX + 1);

  localparam int SCALE =
    (2**PWM_W - 1) / (VOICES * (2**VOL_W - 1));
  localparam int SW = $clog2(VOICES + 1);

  // Half periods in 100 MHz cycles, C3 (code 1) .. B5 (code 36).
  localparam int HB [36] = '{
    382226,
    360773,
    340524,
    321412,
    303373,
    286346,
    270274,
    255105,
    240787,
    227273,
    214517,
    202477,
    191113,
    180387,
    170262,
    160706,
    151686,
    143173,
    135137,
    127553,
    120394,
    113636,
    107258,
    101238,
    95557,
    90193,
    85131,
    80353,
    75843,
    71587,
    67569,
    63776,
    60197,
    56818,
    53629,
    50619
  };

  logic [HW-1:0] rom [36];

  for (genvar i = 0; i < 36; i++) begin : g_rom
    assign rom[i] =
      HW'(longint'(HB[i]) * CLK_HZ / 100000000);
  end

  function automatic logic [HW-1:0] half_of(
    input logic [5:0] n,
    input logic [1:0] o
  );
    logic [HW-1:0] h;
    h = '0;
    if (n >= 6'd1 && n <= 6'd36) h = rom[n - 6'd1];
    case (o)
      2'd1:    h = h >> 1;
      2'd2:    h = h << 1;
      default: h = h;
    endcase
    return h;
  endfunction

  logic [HW-1:0]     nxt      [VOICES];
  logic [HW-1:0]     cur_half [VOICES];
  logic [HW-1:0]     cnt      [VOICES];
  logic [VOICES-1:0] sq;

  logic [SW-1:0]     s;
  logic [PWM_W-1:0]  level;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [PWM_W-1:0]  duty_q;

  // Half period each voice would load if sampled this cycle.
  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      nxt[v] = half_of(note[6*v +: 6], oct[2*v +: 2]);
    end
  end

  // Voice counters: pitch reloads only on half-period boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VOICES; v++) begin
        cur_half[v] <= '0;
        cnt[v]      <= '0;
      end
      sq <= '0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        if (cur_half[v] == '0) begin
          cnt[v]      <= '0;
          cur_half[v] <= nxt[v];
          sq[v]       <= (nxt[v] != '0);
        end else if (cnt[v] == cur_half[v] - HW'(1)) begin
          cnt[v]      <= '0;
          cur_half[v] <= nxt[v];
          sq[v]       <= (nxt[v] != '0) && !sq[v];
        end else begin
          cnt[v] <= cnt[v] + HW'(1);
        end
      end
    end
  end

  // A voice sounds whenever it holds a nonzero half period.
  always_comb begin
    active = '0;
    for (int v = 0; v < VOICES; v++) begin
      active[v] = (cur_half[v] != '0);
    end
  end

  // Mix level: count of high voices times volume times scale.
  always_comb begin
    s = '0;
    for (int v = 0; v < VOICES; v++) begin
      s = s + SW'(sq[v]);
    end
    level = PWM_W'(32'(s) * 32'(vol) * 32'(SCALE));
  end

  // PWM carrier; duty is latched once per carrier period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
      speaker <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (pwm_cnt == '1) duty_q <= level;
      speaker <= (pwm_cnt < duty_q);
    end
  end

endmodule
